c_dcache_stage: RTL

//  Memory (C) stage directly downstream of the execute stage: consumes the ac_* register set and the

---
 rtl/c_dcache_stage_pkg.sv | 19 +
 rtl/c_dcache_stage_array.sv | 58 +++++
 rtl/c_dcache_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/c_dcache_stage_pkg.sv
// Shared types and constants for the C (memory) stage and its data cache storage.
package c_dcache_stage_pkg;

    localparam int unsigned LINE_BITS      = 128;
    localparam int unsigned WORDS_PER_LINE = 4;
    localparam int unsigned OFFSET_BITS    = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StRefill
    } dc_state_e;

    function automatic logic [31:0] line_word(input logic [LINE_BITS-1:0] line,
                                              input logic [1:0]           offset);
        return line[32*offset +: 32];
    endfunction

endpackage

// File: rtl/c_dcache_stage_array.sv
// Direct-mapped tag/valid/dirty/data storage: one combinational read port, a full-line
// refill port and a single-word store port. Only valid/dirty are cleared by reset.
module c_dcache_stage_array
    import c_dcache_stage_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 2,
    localparam int unsigned TAG_BITS  = 32 - INDEX_BITS - OFFSET_BITS,
    localparam int unsigned LINES     = 1 << INDEX_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic                  line_we,
    input  logic [INDEX_BITS-1:0] line_index,
    input  logic [TAG_BITS-1:0]   line_tag,
    input  logic [LINE_BITS-1:0]  line_data,
    input  logic                  word_we,
    input  logic [INDEX_BITS-1:0] word_index,
    input  logic [1:0]            word_offset,
    input  logic [31:0]           word_data
);

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_BITS-1:0]  tag_q  [LINES];
    logic [LINE_BITS-1:0] data_q [LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we) begin
            valid_q[line_index] <= 1'b1;
            dirty_q[line_index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[word_index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (line_we) begin
            tag_q[line_index]  <= line_tag;
            data_q[line_index] <= line_data;
        end else if (word_we) begin
            data_q[word_index][32*word_offset +: 32] <= word_data;
        end
    end

endmodule

// File: rtl/c_dcache_stage.sv
// Memory stage: direct-mapped write-back/write-allocate data cache, miss FSM and the
// cw_* pipeline register feeding writeback.
module c_dcache_stage
    import c_dcache_stage_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 icache_stall,
    input  logic [31:0]          ac_pc,
    input  logic [4:0]           ac_write_sel,
    input  logic                 ac_is_load,
    input  logic                 ac_is_store,
    input  logic                 ac_is_wb,
    input  logic [31:0]          ac_alu_result,
    input  logic [31:0]          ac_data2,
    output logic                 dcache_stall,
    output logic [31:0]          cw_pc,
    output logic                 cw_is_wb,
    output logic [4:0]           cw_write_sel,
    output logic [31:0]          cw_result,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_ready,
    input  logic [LINE_BITS-1:0] mem_rdata
);

    localparam int unsigned TAG_BITS = 32 - INDEX_BITS - OFFSET_BITS;

    dc_state_e             state_q;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] req_index;
    logic [1:0]            req_offset;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [LINE_BITS-1:0]  rd_line;
    logic                  is_mem;
    logic                  hit;
    logic                  miss;
    logic                  line_we;
    logic                  word_we;
    logic                  unused_addr_lsbs;

    assign req_offset       = ac_alu_result[3:2];
    assign req_index        = ac_alu_result[OFFSET_BITS +: INDEX_BITS];
    assign req_tag          = ac_alu_result[31 -: TAG_BITS];
    assign unused_addr_lsbs = ^ac_alu_result[1:0];

    assign is_mem       = ac_is_load | ac_is_store;
    assign hit          = rd_valid && (rd_tag == req_tag);
    assign miss         = is_mem && !hit;
    assign dcache_stall = miss || (state_q != StIdle);

    // Refill lands with mem_ready; the frozen request then hits in IDLE on the next cycle.
    assign line_we = (state_q == StRefill) && mem_ready;
    assign word_we = (state_q == StIdle) && ac_is_store && hit && !icache_stall;

    c_dcache_stage_array #(
        .INDEX_BITS (INDEX_BITS)
    ) u_array (
        .clock       (clock),
        .reset       (reset),
        .rd_index    (req_index),
        .rd_valid    (rd_valid),
        .rd_dirty    (rd_dirty),
        .rd_tag      (rd_tag),
        .rd_line     (rd_line),
        .line_we     (line_we),
        .line_index  (req_index),
        .line_tag    (req_tag),
        .line_data   (mem_rdata),
        .word_we     (word_we),
        .word_index  (req_index),
        .word_offset (req_offset),
        .word_data   (ac_data2)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (miss) begin
                        mem_req <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_q   <= StWriteback;
                            mem_we    <= 1'b1;
                            mem_addr  <= {rd_tag, req_index, 4'b0000};
                            mem_wdata <= rd_line;
                        end else begin
                            state_q  <= StRefill;
                            mem_we   <= 1'b0;
                            mem_addr <= {req_tag, req_index, 4'b0000};
                        end
                    end
                end
                StWriteback: begin
                    if (mem_ready) begin
                        state_q  <= StRefill;
                        mem_we   <= 1'b0;
                        mem_addr <= {req_tag, req_index, 4'b0000};
                    end
                end
                StRefill: begin
                    if (mem_ready) begin
                        state_q <= StIdle;
                        mem_req <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cw_pc        <= '0;
            cw_is_wb     <= 1'b0;
            cw_write_sel <= '0;
            cw_result    <= '0;
        end else if (dcache_stall) begin
            cw_is_wb <= 1'b0;
        end else if (!icache_stall) begin
            cw_pc        <= ac_pc;
            cw_is_wb     <= ac_is_wb;
            cw_write_sel <= ac_write_sel;
            cw_result    <= ac_is_load ? line_word(rd_line, req_offset) : ac_alu_result;
        end
    end

endmodule
